// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch stage: FSM states, instruction
// field positions and PC arithmetic.
package instr_fetch_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_FETCH   = 2'd1,
      ST_HOLD    = 2'd2,
      ST_DISCARD = 2'd3
   } state_t;

   localparam int OPCODE_MSB = 31;
   localparam int OPCODE_LSB = 26;
   localparam int RS_MSB     = 25;
   localparam int RS_LSB     = 21;
   localparam int RT_MSB     = 20;
   localparam int RT_LSB     = 16;
   localparam int IMM_MSB    = 15;
   localparam int IMM_LSB    = 0;

   localparam int PC_STEP_DEFAULT = 4;

   // 32-bit add; the carry out is dropped so the PC wraps modulo 2^32
   function automatic logic [31:0] pc_add(input logic [31:0] pc, input logic [31:0] step);
      return pc + step;
   endfunction

endpackage

// File: rtl/instr_fetch.sv
// Single-entry instruction fetch stage: requests words from instruction memory,
// buffers one instruction for decode and handles redirects mid-request.
module instr_fetch
   import instr_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          PC_STEP  = PC_STEP_DEFAULT
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_pc,
   output logic [5:0]  out_opcode,
   output logic [4:0]  out_rs,
   output logic [4:0]  out_rt,
   output logic [15:0] out_imm16
);

   state_t      state_r, state_s;
   logic [31:0] pc_r, pc_s;
   logic [31:0] tgt_r, tgt_s;
   logic [31:0] instr_r, instr_s;
   logic [31:0] out_pc_r, out_pc_s;
   logic        out_valid_r, out_valid_s;
   logic        imem_req_r, imem_req_s;

   // Next-state, PC, redirect target and output-buffer logic
   always_comb begin
      state_s     = state_r;
      pc_s        = pc_r;
      tgt_s       = tgt_r;
      instr_s     = instr_r;
      out_pc_s    = out_pc_r;
      out_valid_s = out_valid_r;
      case (state_r)
         ST_IDLE: begin
            state_s = ST_FETCH;
            if (redirect_valid) begin
               pc_s = redirect_pc;
            end else begin
               pc_s = pc_r;
            end
         end
         ST_FETCH: begin
            if (redirect_valid) begin
               if (imem_ack) begin
                  pc_s = redirect_pc;
               end else begin
                  // Request already issued at the old PC; wait for it to drain
                  tgt_s   = redirect_pc;
                  state_s = ST_DISCARD;
               end
            end else if (imem_ack) begin
               instr_s     = imem_rdata;
               out_pc_s    = pc_r;
               pc_s        = pc_add(pc_r, 32'(PC_STEP));
               out_valid_s = 1'b1;
               state_s     = ST_HOLD;
            end else begin
               state_s = ST_FETCH;
            end
         end
         ST_DISCARD: begin
            if (redirect_valid) begin
               if (imem_ack) begin
                  pc_s    = redirect_pc;
                  state_s = ST_FETCH;
               end else begin
                  tgt_s = redirect_pc;
               end
            end else if (imem_ack) begin
               pc_s    = tgt_r;
               state_s = ST_FETCH;
            end else begin
               state_s = ST_DISCARD;
            end
         end
         ST_HOLD: begin
            if (redirect_valid) begin
               out_valid_s = 1'b0;
               pc_s        = redirect_pc;
               state_s     = ST_FETCH;
            end else if (out_ready) begin
               out_valid_s = 1'b0;
               state_s     = ST_FETCH;
            end else begin
               state_s = ST_HOLD;
            end
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
      imem_req_s = (state_s == ST_FETCH) || (state_s == ST_DISCARD);
   end

   // State and output registers; reset abandons any outstanding transaction
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= ST_IDLE;
         pc_r        <= RESET_PC;
         tgt_r       <= 32'h0000_0000;
         instr_r     <= 32'h0000_0000;
         out_pc_r    <= 32'h0000_0000;
         out_valid_r <= 1'b0;
         imem_req_r  <= 1'b0;
      end else begin
         state_r     <= state_s;
         pc_r        <= pc_s;
         tgt_r       <= tgt_s;
         instr_r     <= instr_s;
         out_pc_r    <= out_pc_s;
         out_valid_r <= out_valid_s;
         imem_req_r  <= imem_req_s;
      end
   end

   assign imem_req   = imem_req_r;
   assign imem_addr  = pc_r;
   assign out_valid  = out_valid_r;
   assign out_pc     = out_pc_r;
   assign out_opcode = instr_r[OPCODE_MSB:OPCODE_LSB];
   assign out_rs     = instr_r[RS_MSB:RS_LSB];
   assign out_rt     = instr_r[RT_MSB:RT_LSB];
   assign out_imm16  = instr_r[IMM_MSB:IMM_LSB];

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: vector table through a scoreboard plus
// directed stall, redirect, reset and PC-wrap sequences.
module tb_instr_fetch;

   typedef struct {
      logic [31:0] rdata;
      int          lat;
      logic [5:0]  op;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [15:0] imm;
   } vec_t;

   typedef struct {
      logic [31:0] pc;
      logic [5:0]  op;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [15:0] imm;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        imem_req, imem_ack, redirect_valid, out_valid, out_ready;
   logic [31:0] imem_addr, imem_rdata, redirect_pc, out_pc;
   logic [5:0]  out_opcode;
   logic [4:0]  out_rs, out_rt;
   logic [15:0] out_imm16;

   logic        w_req, w_ack, w_valid;
   logic [31:0] w_addr, w_pc;
   logic [5:0]  w_op;
   logic [4:0]  w_rs, w_rt;
   logic [15:0] w_imm;

   int          n_pass = 0;
   int          n_total = 0;
   int          hs_cnt = 0;
   logic [31:0] exp_pc;
   exp_t        sb[$];
   vec_t        vt[5];

   always #5 clk = ~clk;

   instr_fetch dut (
      .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata), .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc), .out_valid(out_valid), .out_ready(out_ready),
      .out_pc(out_pc), .out_opcode(out_opcode), .out_rs(out_rs), .out_rt(out_rt),
      .out_imm16(out_imm16)
   );

   instr_fetch #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
      .clk(clk), .rst_n(rst_n), .imem_req(w_req), .imem_addr(w_addr),
      .imem_ack(w_ack), .imem_rdata(32'h0000_0000), .redirect_valid(1'b0),
      .redirect_pc(32'h0000_0000), .out_valid(w_valid), .out_ready(1'b1),
      .out_pc(w_pc), .out_opcode(w_op), .out_rs(w_rs), .out_rt(w_rt),
      .out_imm16(w_imm)
   );

   // Count completed output handshakes
   always @(posedge clk) begin
      if (rst_n && out_valid && out_ready) hs_cnt <= hs_cnt + 1;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic fetch_one(input vec_t v, input logic rdy);
      int   n;
      exp_t e;
      n = 0;
      while (!imem_req && n < 8) begin
         tick();
         n++;
      end
      chk("imem_req", 32'(imem_req), 32'd1);
      chk("imem_addr", imem_addr, exp_pc);
      for (int i = 1; i < v.lat; i++) begin
         tick();
         chk("addr_stable", imem_addr, exp_pc);
      end
      out_ready  = rdy;
      imem_ack   = 1'b1;
      imem_rdata = v.rdata;
      e = '{exp_pc, v.op, v.rs, v.rt, v.imm};
      sb.push_back(e);
      tick();
      imem_ack   = 1'b0;
      imem_rdata = $urandom();
      exp_pc     = exp_pc + 32'd4;
      chk("out_valid", 32'(out_valid), 32'd1);
      chk("req_in_hold", 32'(imem_req), 32'd0);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk("out_pc", out_pc, e.pc);
         chk("out_opcode", 32'(out_opcode), 32'(e.op));
         chk("out_rs", 32'(out_rs), 32'(e.rs));
         chk("out_rt", 32'(out_rt), 32'(e.rt));
         chk("out_imm16", 32'(out_imm16), 32'(e.imm));
      end
   endtask

   initial begin
      vt[0] = '{32'h8C22_FFF0, 2, 6'h23, 5'd1,  5'd2,  16'hFFF0};
      vt[1] = '{32'hFFFF_FFFF, 1, 6'h3F, 5'd31, 5'd31, 16'hFFFF};
      vt[2] = '{32'h0000_0000, 3, 6'h00, 5'd0,  5'd0,  16'h0000};
      vt[3] = '{32'h20A5_0007, 1, 6'h08, 5'd5,  5'd5,  16'h0007};
      vt[4] = '{32'hAC64_8000, 2, 6'h2B, 5'd3,  5'd4,  16'h8000};

      rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = 32'h0; redirect_valid = 1'b0;
      redirect_pc = 32'h0; out_ready = 1'b0; w_ack = 1'b0;
      tick(); tick();
      chk("rst_req", 32'(imem_req), 32'd0);
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_addr", imem_addr, 32'h0);
      chk("rst_out_pc", out_pc, 32'h0);
      chk("rst_fields", {out_opcode, out_rs, out_rt, out_imm16}, 32'h0);
      chk("rst_wrap_addr", w_addr, 32'hFFFF_FFFC);

      rst_n = 1'b1;
      exp_pc = 32'h0;
      tick();
      for (int k = 0; k < 5; k++) begin
         fetch_one(vt[k], 1'b1);
         tick();
         chk("valid_drop", 32'(out_valid), 32'd0);
      end

      // Stall in HOLD for five cycles; a stray ack must be ignored
      fetch_one(vt[1], 1'b0);
      for (int i = 0; i < 5; i++) begin
         if (i == 2) begin
            imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
         end
         tick();
         imem_ack = 1'b0;
         chk("stall_valid", 32'(out_valid), 32'd1);
         chk("stall_op_imm", {10'd0, out_opcode, out_imm16}, {10'd0, 6'h3F, 16'hFFFF});
         chk("stall_pc", out_pc, exp_pc - 32'd4);
         chk("stall_req", 32'(imem_req), 32'd0);
         chk("stall_addr", imem_addr, exp_pc);
      end
      out_ready = 1'b1;
      tick();
      chk("resume_valid", 32'(out_valid), 32'd0);
      chk("resume_addr", imem_addr, exp_pc);

      // Redirect coinciding with ack: data dropped, stay fetching at target
      redirect_valid = 1'b1; redirect_pc = 32'h8; imem_ack = 1'b1; imem_rdata = 32'hFFFF_FFFF;
      tick();
      redirect_valid = 1'b0; imem_ack = 1'b0;
      chk("rd_ack_valid", 32'(out_valid), 32'd0);
      chk("rd_ack_addr", imem_addr, 32'h8);
      tick();
      redirect_valid = 1'b1; redirect_pc = 32'h100;
      tick();
      redirect_valid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         chk("disc_addr", imem_addr, 32'h8);
         chk("disc_req", 32'(imem_req), 32'd1);
         chk("disc_valid", 32'(out_valid), 32'd0);
         tick();
      end
      imem_ack = 1'b1; imem_rdata = 32'h8C22_FFF0;
      tick();
      imem_ack = 1'b0;
      chk("disc_done_addr", imem_addr, 32'h100);
      chk("disc_done_valid", 32'(out_valid), 32'd0);
      tick();
      chk("disc_no_hold", 32'(out_valid), 32'd0);

      // A second redirect while discarding replaces the target
      redirect_valid = 1'b1; redirect_pc = 32'h180;
      tick();
      redirect_pc = 32'h1C0;
      tick();
      redirect_valid = 1'b0; imem_ack = 1'b1;
      tick();
      imem_ack = 1'b0;
      chk("overwrite_addr", imem_addr, 32'h1C0);
      exp_pc = 32'h1C0;

      // Redirect in HOLD together with out_ready
      fetch_one(vt[3], 1'b0);
      redirect_valid = 1'b1; redirect_pc = 32'h200; out_ready = 1'b1;
      tick();
      redirect_valid = 1'b0;
      chk("hold_rd_valid", 32'(out_valid), 32'd0);
      chk("hold_rd_addr", imem_addr, 32'h200);
      chk("hold_rd_req", 32'(imem_req), 32'd1);

      // Reset mid-request with an ack arriving during reset
      tick();
      rst_n = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hFFFF_FFFF;
      #1;
      chk("async_req", 32'(imem_req), 32'd0);
      chk("async_valid", 32'(out_valid), 32'd0);
      chk("async_addr", imem_addr, 32'h0);
      chk("async_out_pc", out_pc, 32'h0);
      tick(); tick();
      rst_n = 1'b1; imem_ack = 1'b0;
      tick();
      chk("restart_valid", 32'(out_valid), 32'd0);
      exp_pc = 32'h0;
      fetch_one(vt[0], 1'b1);
      tick();

      chk("handshakes", 32'(hs_cnt), 32'd8);

      // PC wrap on the second instance
      chk("wrap_start", w_addr, 32'hFFFF_FFFC);
      w_ack = 1'b1;
      tick();
      w_ack = 1'b0;
      chk("wrap_valid", 32'(w_valid), 32'd1);
      chk("wrap_out_pc", w_pc, 32'hFFFF_FFFC);
      tick();
      chk("wrap_addr", w_addr, 32'h0);
      chk("wrap_req", 32'(w_req), 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC loaded on reset.
REQ-002 Parameter PC_STEP, default 4: PC increment per accepted instruction.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 imem_req  output  1  instruction-memory read request.
REQ-006 imem_addr  output  32  read address, equals PC of outstanding request.
REQ-007 imem_ack  input  1  memory returns imem_rdata this cycle.
REQ-008 imem_rdata  input  32  instruction word, valid only with imem_ack.
REQ-009 redirect_valid  input  1  branch/jump redirect request.
REQ-010 redirect_pc  input  32  redirect target.
REQ-011 out_valid  output  1  decoded instruction available to the sign-extend/decode stage.
REQ-012 out_ready  input  1  downstream accepts when high with out_valid.
REQ-013 out_pc  output  32  PC of held instruction.
REQ-014 out_opcode  output  6  instr[31:26].
REQ-015 out_rs  output  5  instr[25:21].
REQ-016 out_rt  output  5  instr[20:16].
REQ-017 out_imm16  output  16  instr[15:0], raw, feeds sign extension.

Function
REQ-018 FSM SHALL have states IDLE, FETCH, HOLD, DISCARD; IDLE only entered by reset.
REQ-019 IDLE -> FETCH unconditionally on first clk edge after rst_n deasserts.
REQ-020 imem_req SHALL be 1 exactly in FETCH and DISCARD; imem_addr SHALL stay stable until imem_ack.
REQ-021 FETCH with imem_ack, no redirect: latch imem_rdata and PC into output register, PC += PC_STEP, -> HOLD; out_valid = 1 next cycle (1-cycle latency from ack).
REQ-022 PC addition SHALL wrap modulo 2^32 (32'hFFFF_FFFC + 4 = 0).
REQ-023 HOLD: outputs SHALL hold stable while out_valid && !out_ready; on out_valid && out_ready -> FETCH, out_valid = 0 next cycle.
REQ-024 Redirect has priority over all sequential progress; the latest redirect_pc wins.
REQ-025 Redirect in FETCH with imem_ack same cycle: discard rdata, PC = redirect_pc, stay FETCH.
REQ-026 Redirect in FETCH without imem_ack: store redirect_pc, -> DISCARD; old address held on imem_addr.
REQ-027 DISCARD: on imem_ack drop rdata, PC = stored target, -> FETCH; a further redirect in DISCARD overwrites the stored target.
REQ-028 Redirect in HOLD: out_valid = 0 next cycle, PC = redirect_pc, -> FETCH; if out_ready also high that cycle the transfer counts as completed.
REQ-029 imem_ack outside FETCH/DISCARD SHALL be ignored.
REQ-030 Throughput: at most one instruction per two cycles (single-entry buffer).

Reset
REQ-031 rst_n low SHALL immediately force: state IDLE, PC = RESET_PC, imem_req 0, out_valid 0, out_pc/out_opcode/out_rs/out_rt/out_imm16 all 0.
REQ-032 Reset asserted mid-request or mid-hold SHALL abandon the transaction; a late imem_ack is ignored.

Structure
REQ-033 Shared package SHALL hold the FSM state enum, instruction field bit positions (opcode/rs/rt/imm) and PC_STEP default.
REQ-034 Single module, no sub-module; field extraction is plain slicing of the instruction register.

Verification
REQ-035 Reset release, imem_ack on 2nd request cycle, imem_rdata 32'h8C22_FFF0, out_ready 1 -> imem_addr 0, out_opcode 6'h23, out_rs 1, out_rt 2, out_imm16 16'hFFF0, out_pc 0, next imem_addr 4.
REQ-036 out_ready held 0 for 5 cycles in HOLD -> outputs constant, imem_req 0, no PC change; out_ready 1 -> FETCH at PC+4.
REQ-037 Redirect to 32'h100 while request at 8 unacked, ack 3 cycles later -> imem_addr stays 8 until ack, data dropped, out_valid stays 0, next imem_addr 32'h100.
REQ-038 Redirect to 32'h200 in HOLD with out_ready 1 -> one transfer counted, out_valid 0 next cycle, imem_addr 32'h200.
REQ-039 RESET_PC 32'hFFFF_FFFC, one ack -> next imem_addr 0.
REQ-040 rst_n pulsed low mid-FETCH, ack arriving during reset -> imem_req 0 immediately, out_valid 0, fetch restarts at RESET_PC.
